mac_row_accum: RTL and testbench
================================

Name: mac_row_accum

Overview:
- Downstream consumer of the 16-lane multiplier array; sums the 16 signed products of each cycle in a registered adder tree.
- Accumulates successive 16-product chunks of one matrix row, seeded with that row's bias.
- Emits one saturated WL-bit dot-product per row: the W·x+b gate pre-activation fed to the LSTM activation stage.
- Streaming, no backpressure; accepts one chunk per cycle.

Parameters:
- WL, 16: word length of products, bias and result; signed two's complement, same fixed-point format throughout.
- LANES, 16: products per chunk; fixed at 16 (4-level tree).
- ACC_W, 24: accumulator width, signed; must be ≥ WL+5.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  prod_in/in_last/bias_in valid this cycle.
- in_last  in  1  chunk is the final chunk of the current row.
- prod_in  in  LANES*WL  packed products; lane k at [k*WL +: WL], aligned with multiplier outputs 0..15.
- bias_in  in  WL  row bias; sampled only on the first chunk of a row.
- out_valid  out  1  one-cycle pulse: sum_out holds a finished row.
- sum_out  out  WL  saturated row result.
- out_sat  out  1  qualified by out_valid; 1 if this row's result was clamped, at accumulator or output stage.
- busy  out  1  row in progress, or any pipeline stage holds valid data.

Behaviour:
- Reset, sampled at a clk edge:
  - out_valid=0, sum_out=0, out_sat=0, busy=0.
  - All pipeline valid/first/last tags cleared; accumulator cleared; first-flag set.
  - Reset mid-row discards partial sums and in-flight data; no out_valid results from them.
- First-flag:
  - Set at reset and after any accepted chunk with in_last=1; cleared by any accepted chunk with in_last=0.
  - A chunk accepted while first-flag=1 is a row's first chunk; its bias_in is captured and travels with it in the pipeline.
- Pipeline:
  - T0: chunk sampled (in_valid=1).
  - Adder-tree levels registered at T0+1 (8 sums, WL+1 bits), T0+2 (4 sums, WL+2), T0+3 (2 sums, WL+3), T0+4 (1 sum, WL+4). All sign-extended; no loss inside the tree.
  - Accumulator at T0+5:
    - first chunk: acc ← sext(bias) + tree;
    - otherwise: acc ← acc + tree.
    - The add saturates at ACC_W signed limits and sets a sticky row-saturation bit (cleared on a first chunk unless that chunk saturates).
  - Output at T0+6, only for last chunks:
    - sum_out ← acc clamped to [−2^(WL−1), 2^(WL−1)−1];
    - out_sat ← sticky bit OR output clamp;
    - out_valid=1 for exactly one cycle.
  - Latency: last chunk sampled at T0 → out_valid high in the cycle after edge T0+6.
- Tags: valid/first/last/bias ride with the data through every stage.
- Bubbles (in_valid=0) between chunks are allowed; the accumulator holds.
- A chunk with in_valid=1 and in_last=1 while first-flag=1 is a one-chunk row: bias + tree.
- Back-to-back rows (last of row A, next cycle first of row B): both results correct; out_valid pulses on consecutive cycles.
- sum_out and out_sat hold their last value when out_valid=0.
- busy=0 only when first-flag=1 and no stage holds a valid tag.

Test Plan:
- Reset: hold rst 2 cycles with random inputs → out_valid=0, sum_out=0, busy=0 throughout; no pulse after release.
- Single-chunk row: all lanes 0x0001, bias 0x0010, in_last=1 → exactly 6 cycles later out_valid=1, sum_out=0x0020, out_sat=0.
- Three-chunk row with bubbles:
  - chunks all lanes 0x0100, 0xFF00 (−256), 0x0002, bias 0xFFFF, one idle cycle between each;
  - → sum_out = 4096−4096+32−1 = 0x001F, single pulse 6 cycles after last chunk.
- Back-to-back rows: row A one chunk lanes 0x0003 bias 0; row B next cycle lanes 0xFFFF bias 0x0005 → pulses on consecutive cycles: 0x0030 then 0xFFF5.
- Saturation:
  - four chunks all lanes 0x7FFF → sum_out=0x7FFF, out_sat=1;
  - same with 0x8000 → sum_out=0x8000, out_sat=1;
  - following small row → out_sat=0.
- Reset mid-row: two non-last chunks, rst one cycle, then single-chunk row lanes 0x0001 bias 0 → only pulse is sum_out=0x0010.

Source files
------------

// File: rtl/mac_row_accum.sv
// mac_row_accum: registered 16-lane adder tree feeding a saturating
// row accumulator; emits one clamped WL-bit dot product per row.
module mac_row_accum #(
  parameter int WL    = 16,
  parameter int LANES = 16,
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [LANES*WL-1:0]   prod_in,
  input  logic [WL-1:0]         bias_in,
  output logic                  out_valid,
  output logic [WL-1:0]         sum_out,
  output logic                  out_sat,
  output logic                  busy
);

  localparam int L1W = WL + 1;
  localparam int L2W = WL + 2;
  localparam int L3W = WL + 3;
  localparam int L4W = WL + 4;

  localparam logic signed [ACC_W-1:0] AMAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OHI =
    {{(ACC_W-WL+1){1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OLO =
    {{(ACC_W-WL+1){1'b1}}, {(WL-1){1'b0}}};

  logic                    first_q, first_d;
  logic [4:0]              tv_q, tf_q, tl_q;
  logic signed [WL-1:0]    tb_q [5];
  logic signed [WL-1:0]    s0_q [LANES];
  logic signed [L1W-1:0]   l1_q [8], l1_d [8];
  logic signed [L2W-1:0]   l2_q [4], l2_d [4];
  logic signed [L3W-1:0]   l3_q [2], l3_d [2];
  logic signed [L4W-1:0]   l4_q, l4_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic signed [ACC_W:0]   acc_sum;
  logic                    ovf;
  logic                    sticky_q, sticky_d;
  logic                    acc_vld_q, acc_last_q;
  logic                    out_valid_q, out_sat_q;
  logic [WL-1:0]           sum_out_q, osum;
  logic                    oclamp;

  // Row-start flag: next accepted chunk opens a new row.
  always_comb begin
    first_d = first_q;
    if (in_valid) first_d = in_last;
  end

  // Adder tree: pairwise sign-extended sums, one level per stage.
  always_comb begin
    for (int i = 0; i < 8; i++)
      l1_d[i] = L1W'(s0_q[2*i]) + L1W'(s0_q[2*i+1]);
    for (int i = 0; i < 4; i++)
      l2_d[i] = L2W'(l1_q[2*i]) + L2W'(l1_q[2*i+1]);
    for (int i = 0; i < 2; i++)
      l3_d[i] = L3W'(l2_q[2*i]) + L3W'(l2_q[2*i+1]);
    l4_d = L4W'(l3_q[0]) + L4W'(l3_q[1]);
  end

  // Accumulate with ACC_W saturation and sticky row flag.
  always_comb begin
    acc_base = tf_q[4] ? ACC_W'(tb_q[4]) : acc_q;
    acc_sum  = (ACC_W+1)'(acc_base) + (ACC_W+1)'(l4_q);
    ovf      = acc_sum[ACC_W] != acc_sum[ACC_W-1];
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (tv_q[4]) begin
      if (ovf) acc_d = acc_sum[ACC_W] ? AMIN : AMAX;
      else     acc_d = acc_sum[ACC_W-1:0];
      sticky_d = ovf | (~tf_q[4] & sticky_q);
    end
  end

  // Clamp finished accumulator into WL-bit result range.
  always_comb begin
    oclamp = 1'b0;
    osum   = acc_q[WL-1:0];
    if (acc_q > OHI) begin
      oclamp = 1'b1;
      osum   = OHI[WL-1:0];
    end else if (acc_q < OLO) begin
      oclamp = 1'b1;
      osum   = OLO[WL-1:0];
    end
  end

  // Data path registers; validity is tracked by the tag chain.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++)
      s0_q[k] <= prod_in[k*WL +: WL];
    if (in_valid && first_q) tb_q[0] <= bias_in;
    for (int k = 1; k < 5; k++) tb_q[k] <= tb_q[k-1];
    l1_q <= l1_d;
    l2_q <= l2_d;
    l3_q <= l3_d;
    l4_q <= l4_d;
  end

  // Tags, accumulator and output stage with sync reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q     <= 1'b1;
      tv_q        <= '0;
      tf_q        <= '0;
      tl_q        <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      acc_vld_q   <= 1'b0;
      acc_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      sum_out_q   <= '0;
    end else begin
      first_q     <= first_d;
      tv_q        <= {tv_q[3:0], in_valid};
      tf_q        <= {tf_q[3:0], first_q};
      tl_q        <= {tl_q[3:0], in_last};
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      acc_vld_q   <= tv_q[4];
      acc_last_q  <= tl_q[4];
      out_valid_q <= acc_vld_q & acc_last_q;
      if (acc_vld_q && acc_last_q) begin
        sum_out_q <= osum;
        out_sat_q <= sticky_q | oclamp;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum_out   = sum_out_q;
  assign out_sat   = out_sat_q;
  assign busy      = ~first_q | (|tv_q) | acc_vld_q
                   | out_valid_q;

endmodule

// File: tb/tb_mac_row_accum.sv
// tb_mac_row_accum: directed and random rows checked against
// an arithmetic row model with a timed expected-result queue.
module tb_mac_row_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_last;
  logic [255:0] prod_in;
  logic [15:0]  bias_in;
  logic         out_valid;
  logic [15:0]  sum_out;
  logic         out_sat;
  logic         busy;

  mac_row_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .prod_in   (prod_in),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .sum_out   (sum_out),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] sum;
    logic        sat;
  } exp_t;

  exp_t        pq[$];
  logic [15:0] lanes [16];
  logic [15:0] bias;
  int          cyc;
  int          n_chk;
  int          n_pass;
  bit          m_first;
  longint      m_acc;
  bit          m_sticky;
  int          busy_until;
  logic [15:0] last_sum;
  logic        last_sat;

  localparam longint AMAXL = (64'sd1 <<< 23) - 1;
  localparam longint AMINL = -(64'sd1 <<< 23);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h",
                  tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    pq.delete();
    m_first    = 1'b1;
    m_acc      = 0;
    m_sticky   = 1'b0;
    busy_until = -1;
    last_sum   = '0;
    last_sat   = 1'b0;
  endtask

  task automatic model_accept(input bit l);
    longint tree, s, o;
    bit     sat, osat;
    exp_t   e;
    tree = 0;
    for (int k = 0; k < 16; k++)
      tree += longint'($signed(lanes[k]));
    s = (m_first ? longint'($signed(bias)) : m_acc) + tree;
    sat = 1'b0;
    if (s > AMAXL) begin s = AMAXL; sat = 1'b1; end
    if (s < AMINL) begin s = AMINL; sat = 1'b1; end
    m_sticky = m_first ? sat : (m_sticky | sat);
    m_acc = s;
    if (l) begin
      o = s;
      osat = m_sticky;
      if (o > 32767)  begin o = 32767;  osat = 1'b1; end
      if (o < -32768) begin o = -32768; osat = 1'b1; end
      e.due = cyc + 6;
      e.sum = 16'(o);
      e.sat = osat;
      pq.push_back(e);
    end
    busy_until = cyc + (l ? 6 : 5);
    m_first = l;
  endtask

  task automatic step(input bit v, input bit l, input bit r);
    bit ev;
    rst      = r;
    in_valid = v;
    in_last  = l;
    bias_in  = bias;
    for (int k = 0; k < 16; k++) prod_in[k*16 +: 16] = lanes[k];
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else if (v) model_accept(l);
    @(negedge clk);
    ev = pq.size() > 0 && pq[0].due == cyc;
    check("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      last_sum = pq[0].sum;
      last_sat = pq[0].sat;
      void'(pq.pop_front());
      check("out_sat", 32'(out_sat), 32'(last_sat));
    end
    check("sum_out", 32'(sum_out), 32'(last_sum));
    check("busy", 32'(busy),
          32'(!m_first || cyc <= busy_until));
  endtask

  task automatic fill(input logic [15:0] val);
    for (int k = 0; k < 16; k++) lanes[k] = val;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    model_reset();
    fill(16'h0);
    bias = '0;
    for (int i = 0; i < 2; i++) begin
      fill(16'($urandom));
      bias = 16'($urandom);
      step(1'($urandom), 1'($urandom), 1'b1);
    end
    idle(8);

    fill(16'h0001); bias = 16'h0010;
    step(1'b1, 1'b1, 1'b0);
    idle(8);

    bias = 16'hFFFF; fill(16'h0100);
    step(1'b1, 1'b0, 1'b0); idle(1);
    bias = 16'h1234; fill(16'hFF00);
    step(1'b1, 1'b0, 1'b0); idle(1);
    fill(16'h0002);
    step(1'b1, 1'b1, 1'b0);
    idle(8);

    fill(16'h0003); bias = 16'h0000;
    step(1'b1, 1'b1, 1'b0);
    fill(16'hFFFF); bias = 16'h0005;
    step(1'b1, 1'b1, 1'b0);
    idle(8);

    fill(16'h7FFF); bias = 16'h0;
    for (int i = 0; i < 4; i++) step(1'b1, i == 3, 1'b0);
    fill(16'h8000);
    for (int i = 0; i < 4; i++) step(1'b1, i == 3, 1'b0);
    fill(16'h0002); bias = 16'h0001;
    step(1'b1, 1'b1, 1'b0);
    idle(8);

    fill(16'h0400); bias = 16'h0100;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    fill(16'h0001); bias = 16'h0;
    step(1'b1, 1'b1, 1'b0);
    idle(8);

    for (int i = 0; i < 600; i++) begin
      bit big;
      big = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 16; k++)
        lanes[k] = big ? 16'($urandom)
                       : 16'($urandom_range(0, 511) - 256);
      bias = big ? 16'($urandom)
                 : 16'($urandom_range(0, 511) - 256);
      step(1'($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 99) == 0));
    end
    step(1'b1, 1'b1, 1'b0);
    idle(10);
    check("drain", 32'(pq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
